// File: rtl/systolic_skew_feeder.sv
// Vector FIFO feeding the edge of a systolic array; row i of each popped vector is delayed i en-cycles.
// Latency: pushed vector is poppable the next edge; on a pop at en-edge t, row i is output after en-edge t+i (t when SKEW=0).
module systolic_skew_feeder #(
    parameter int DIM   = 8,
    parameter int BITS  = 64,
    parameter int DEPTH = 8,
    parameter int SKEW  = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BITS-1:0]            in_data [DIM],
    input  logic                       en,
    output logic [BITS-1:0]            out_data [DIM],
    output logic [DIM-1:0]             out_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [BITS-1:0] mem_q [DEPTH][DIM];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop;

    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign in_ready = !full;

    // Fullness is judged before any same-edge pop, so a full FIFO never overwrites.
    always_comb begin
        push     = in_valid && !full && !clr;
        pop      = en && !empty && !clr;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            for (int r = 0; r < DIM; r++) begin
                mem_q[wr_ptr_q][r] <= in_data[r];
            end
        end
    end

    for (genvar r = 0; r < DIM; r++) begin : g_row
        localparam int NST = (SKEW != 0) ? r + 1 : 1;

        logic [BITS-1:0] dat_q [NST];
        logic [BITS-1:0] dat_d [NST];
        logic [NST-1:0]  vld_q, vld_d;

        // Stage 0 takes the popped element, or a zero bubble when en finds the FIFO empty.
        always_comb begin
            dat_d = dat_q;
            vld_d = vld_q;
            if (clr) begin
                for (int s = 0; s < NST; s++) dat_d[s] = '0;
                vld_d = '0;
            end else if (en) begin
                dat_d[0] = pop ? mem_q[rd_ptr_q][r] : '0;
                vld_d[0] = pop;
                for (int s = 1; s < NST; s++) begin
                    dat_d[s] = dat_q[s-1];
                    vld_d[s] = vld_q[s-1];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s < NST; s++) dat_q[s] <= '0;
                vld_q <= '0;
            end else begin
                dat_q <= dat_d;
                vld_q <= vld_d;
            end
        end

        assign out_data[r]  = dat_q[NST-1];
        assign out_valid[r] = vld_q[NST-1];
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Drives a SKEW=1 and a SKEW=0 feeder with identical stimulus and scoreboards both against a queue model.
module tb_systolic_skew_feeder;

    localparam int DIM = 4, BITS = 8, DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n, clr, in_valid, en;
    logic [BITS-1:0]  in_data [DIM];
    logic             in_ready1, in_ready0;
    logic [BITS-1:0]  od1 [DIM];
    logic [BITS-1:0]  od0 [DIM];
    logic [DIM-1:0]   ov1, ov0;
    logic [2:0]       cnt1, cnt0;
    logic             empty1, empty0, full1, full0;

    always #5 clk = ~clk;

    systolic_skew_feeder #(.DIM(DIM), .BITS(BITS), .DEPTH(DEPTH), .SKEW(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .en(en), .out_data(od1), .out_valid(ov1), .count(cnt1),
        .empty(empty1), .full(full1));

    systolic_skew_feeder #(.DIM(DIM), .BITS(BITS), .DEPTH(DEPTH), .SKEW(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .en(en), .out_data(od0), .out_valid(ov0), .count(cnt0),
        .empty(empty0), .full(full0));

    typedef struct {
        logic [7:0] d;
        int         due;
    } exp_t;

    exp_t        q [2][DIM][$];
    logic [31:0] mfifo [$];
    int          mcnt = 0;
    int          en_edges = 0;
    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        mfifo.delete();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < DIM; i++) q[k][i].delete();
        mcnt = 0;
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            logic [DIM-1:0] ev;
            ev = '0;
            for (int i = 0; i < DIM; i++) begin
                logic [7:0] ed;
                logic [7:0] gd;
                while (q[k][i].size() > 0 && q[k][i][0].due < en_edges) void'(q[k][i].pop_front());
                ed = 8'h00;
                if (q[k][i].size() > 0 && q[k][i][0].due == en_edges) begin
                    ev[i] = 1'b1;
                    ed    = q[k][i][0].d;
                end
                gd = (k == 1) ? od1[i] : od0[i];
                chk($sformatf("data_s%0d_r%0d", k, i), gd, ed);
            end
            chk($sformatf("valid_s%0d", k), (k == 1) ? ov1 : ov0, ev);
            chk($sformatf("count_s%0d", k), (k == 1) ? cnt1 : cnt0, mcnt);
            chk($sformatf("empty_s%0d", k), (k == 1) ? empty1 : empty0, mcnt == 0);
            chk($sformatf("full_s%0d", k), (k == 1) ? full1 : full0, mcnt == DEPTH);
            chk($sformatf("ready_s%0d", k), (k == 1) ? in_ready1 : in_ready0, mcnt != DEPTH);
        end
    endtask

    // One clock: drive at the falling edge, update the model at the rising edge, compare 1ns later.
    task automatic cyc(input bit v, input logic [31:0] dv, input bit e, input bit c);
        bit          do_push, do_pop;
        logic [31:0] pv;
        in_valid = v;
        for (int i = 0; i < DIM; i++) in_data[i] = dv[8*i +: 8];
        en  = e;
        clr = c;
        do_push = v && (mcnt < DEPTH) && !c;
        do_pop  = e && (mcnt > 0) && !c;
        @(posedge clk);
        #1;
        if (c) begin
            clear_model();
        end else begin
            if (e) en_edges++;
            if (do_pop) begin
                pv = mfifo.pop_front();
                for (int i = 0; i < DIM; i++) begin
                    q[1][i].push_back('{d: pv[8*i +: 8], due: en_edges + i});
                    q[0][i].push_back('{d: pv[8*i +: 8], due: en_edges});
                end
            end
            if (do_push) mfifo.push_back(dv);
        end
        mcnt = mfifo.size();
        check_outputs();
        @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        en       = 1'b0;
        for (int i = 0; i < DIM; i++) in_data[i] = '0;
        #12;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Skew: one vector, then en; row i shows its element after en-edge i+1.
        cyc(1, 32'h13121110, 0, 0);
        cyc(0, 0, 1, 0);
        chk("skew_r0_edge1", od1[0], 8'h10);
        chk("skew0_all_edge1", ov0, 4'b1111);
        for (int n = 0; n < 3; n++) cyc(0, 0, 1, 0);
        chk("skew_r3_edge4", od1[3], 8'h13);
        chk("skew_valid_edge4", ov1, 4'b1000);
        cyc(0, 0, 1, 0);

        // Full: fifth push dropped, pops come back in order.
        for (int n = 0; n < 5; n++) cyc(1, 32'h20202020 + n, 0, 0);
        chk("full_flag", full1, 1'b1);
        chk("full_ready", in_ready1, 1'b0);
        chk("full_count", cnt1, 3'd4);
        cyc(1, 32'h55555555, 1, 0);
        for (int n = 0; n < 8; n++) cyc(0, 0, 1, 0);

        // Concurrent push+pop at count 2, then enough traffic to wrap pointers.
        cyc(1, 32'hA3A2A1A0, 0, 0);
        cyc(1, 32'hB3B2B1B0, 0, 0);
        cyc(1, 32'hC3C2C1C0, 1, 0);
        chk("pushpop_count", cnt1, 3'd2);
        for (int n = 0; n < 7; n++) cyc(1, 32'h30303030 + n, n % 2, 0);
        for (int n = 0; n < 10; n++) cyc(0, 0, 1, 0);

        // Stall then flush; the push during clr must not be stored.
        cyc(1, 32'h43424140, 0, 0);
        cyc(1, 32'h47464544, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        for (int n = 0; n < 3; n++) cyc(0, 0, 0, 0);
        cyc(1, 32'h99999999, 0, 1);
        chk("clr_count", cnt1, 3'd0);
        chk("clr_valid", ov1, 4'b0000);
        for (int n = 0; n < 5; n++) cyc(0, 0, 1, 0);

        // Asynchronous reset mid-stream.
        cyc(1, 32'h63626160, 0, 0);
        cyc(1, 32'h67666564, 1, 0);
        cyc(0, 0, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        clear_model();
        check_outputs();
        in_valid = 1'b0;
        en       = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 32'h73727170, 1, 0);
        for (int n = 0; n < 6; n++) cyc(0, 0, 1, 0);

        // Random traffic with occasional flushes.
        for (int n = 0; n < 300; n++)
            cyc($urandom_range(0, 1), $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
        for (int n = 0; n < 12; n++) cyc(0, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
